// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one init/done square-root core among N requesters.
// Optional abort on a hung core: define SQRT_TIMEOUT_EN (adds the TIMEOUT parameter).
module sqrt_arbiter #(
  parameter int N = 4,
  parameter int W = 16
`ifdef SQRT_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic [N*W-1:0]   operand_i,
  output logic [N-1:0]     ack_o,
  output logic [N-1:0]     rsp_valid_o,
  output logic [W/2-1:0]   rsp_data_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic             core_init_o,
  output logic [W-1:0]     core_operand_o,
  input  logic             core_done_i,
  input  logic [W/2-1:0]   core_result_i,
  output logic             core_rst_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_CAPTURE,
    S_WAIT_CLR
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]  gnt_s;
  logic [W-1:0]   operand_q, operand_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [N-1:0]   rsp_valid_q, rsp_valid_d;
  logic [W/2-1:0] rsp_data_q, rsp_data_d;
  logic           init_q, init_d;
  logic           busy_q, busy_d;

`ifdef SQRT_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rsp_err_q, rsp_err_d;
  logic           core_rst_q, core_rst_d;
`endif

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return s[IW-1:0];
  endfunction

  // Lowest offset from the rr pointer wins: scan downward so the nearest set bit is written last.
  always_comb begin
    gnt_s = rr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(rr_q, k)]) begin
        gnt_s = wrap_idx(rr_q, k);
      end else begin
        gnt_s = gnt_s;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    operand_d   = operand_q;
    ack_d       = '0;
    init_d      = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef SQRT_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
    core_rst_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          gnt_d        = gnt_s;
          rr_d         = wrap_idx(gnt_s, 1);
          operand_d    = operand_i[gnt_s*W +: W];
          ack_d[gnt_s] = 1'b1;
          init_d       = 1'b1;
          state_d      = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_DONE;
`ifdef SQRT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      // A done level seen here can only belong to this dispatch: WAIT_CLR saw the last one fall.
      S_WAIT_DONE: begin
        if (core_done_i) begin
          state_d              = S_CAPTURE;
          rsp_valid_d[gnt_q]   = 1'b1;
          rsp_data_d           = core_result_i;
        end
`ifdef SQRT_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d            = S_IDLE;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_data_d         = '0;
          rsp_err_d          = 1'b1;
          core_rst_d         = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        else begin
          state_d = S_WAIT_DONE;
        end
`endif
      end
      S_CAPTURE: begin
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!core_done_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_CLR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      operand_q   <= '0;
      ack_q       <= '0;
      init_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef SQRT_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      core_rst_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      operand_q   <= operand_d;
      ack_q       <= ack_d;
      init_q      <= init_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef SQRT_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      core_rst_q  <= core_rst_d;
`endif
    end
  end

  assign ack_o          = ack_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign busy_o         = busy_q;
  assign core_init_o    = init_q;
  assign core_operand_o = operand_q;
`ifdef SQRT_TIMEOUT_EN
  assign rsp_err_o      = rsp_err_q;
  assign core_rst_o     = core_rst_q;
`else
  assign rsp_err_o      = 1'b0;
  assign core_rst_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed self-checking bench for sqrt_arbiter with a behavioural sqrt core
// (4-cycle latency, done held 31 cycles).
module tb_sqrt_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] operand;
  logic [3:0]  ack_o;
  logic [3:0]  rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        core_init_o;
  logic [15:0] core_operand_o;
  logic        core_done;
  logic [7:0]  core_result;
  logic        core_rst_o;
  logic        hang;

  int n_cmp = 0;
  int n_err = 0;
  int gnt_log[$];
  int ev_log[$];
  int rsp_idx_log[$];
  int rsp_data_log[$];
  int rsp_err_log[$];

  sqrt_arbiter #(
    .N(4),
    .W(16)
`ifdef SQRT_TIMEOUT_EN
    ,
    .TIMEOUT(20)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .operand_i      (operand),
    .ack_o          (ack_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o),
    .core_init_o    (core_init_o),
    .core_operand_o (core_operand_o),
    .core_done_i    (core_done),
    .core_result_i  (core_result),
    .core_rst_o     (core_rst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int r;
    int t;
    r = 0;
    for (int b = 7; b >= 0; b--) begin
      t = r | (1 << b);
      if (t * t <= int'(v)) r = t;
    end
    return 8'(r);
  endfunction

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural core: done rises 4 cycles after init and is held for 31 cycles.
  int lat_m;
  int hold_m;
  always @(posedge clk) begin
    if (rst || core_rst_o) begin
      core_done   <= 1'b0;
      core_result <= 8'd0;
      lat_m       <= 0;
      hold_m      <= 0;
    end else if (core_init_o && !hang) begin
      lat_m       <= 4;
      core_done   <= 1'b0;
      core_result <= isqrt(core_operand_o);
    end else if (lat_m > 0) begin
      lat_m <= lat_m - 1;
      if (lat_m == 1) begin
        core_done <= 1'b1;
        hold_m    <= 31;
      end
    end else if (hold_m > 0) begin
      hold_m <= hold_m - 1;
      if (hold_m == 1) core_done <= 1'b0;
    end
  end

  // Event monitor: every dispatch must be a single ack with init, issued only while done is low.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack_o != 4'b0 || core_init_o) begin
        check("ack_onehot", 32'($countones(ack_o)), 32'd1);
        check("init_with_ack", 32'(core_init_o), 32'd1);
        check("init_done_low", 32'(core_done), 32'd0);
        gnt_log.push_back(oh2idx(ack_o));
        ev_log.push_back(100 + oh2idx(ack_o));
      end
      if (rsp_valid_o != 4'b0) begin
        check("rsp_onehot", 32'($countones(rsp_valid_o)), 32'd1);
        rsp_idx_log.push_back(oh2idx(rsp_valid_o));
        rsp_data_log.push_back(int'(rsp_data_o));
        rsp_err_log.push_back(int'(rsp_err_o));
        ev_log.push_back(200 + oh2idx(rsp_valid_o));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requesters drop req after ack; with reraise they raise it again one cycle later.
  task automatic run(input int max_cyc, input int target, input bit reraise, output bit ok);
    logic [3:0] prev;
    prev = 4'b0;
    ok   = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      req  = (req & ~ack_o) | (reraise ? prev : 4'b0);
      prev = ack_o;
      if (rsp_idx_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack_o), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data_o), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_core_init"}, 32'(core_init_o), 32'd0);
    check({tag, "_core_operand"}, 32'(core_operand_o), 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst_o), 32'd0);
  endtask

  initial begin
    bit ok;
    int rb;
    int gb;
    int eb;
    int n;
    bit seen;
    rst     = 1'b1;
    req     = 4'b0;
    operand = 64'd0;
    hang    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single request: 144 -> 12, one response despite long done
    rb = rsp_idx_log.size();
    operand[15:0] = 16'd144;
    req = 4'b0001;
    @(negedge clk);
    check("single_ack_lat", 32'(ack_o), 32'd1);
    check("single_init", 32'(core_init_o), 32'd1);
    check("single_operand", 32'(core_operand_o), 32'd144);
    check("single_busy", 32'(busy_o), 32'd1);
    req = req & ~ack_o;
    run(200, rb + 1, 1'b0, ok);
    check("single_rsp_seen", 32'(ok), 32'd1);
    if (ok) begin
      check("single_rsp_idx", rsp_idx_log[rb], 0);
      check("single_rsp_data", rsp_data_log[rb], 12);
      check("single_rsp_err", rsp_err_log[rb], 0);
    end
    run(60, 1000, 1'b0, ok);
    check("single_one_pulse", rsp_idx_log.size() - rb, 1);
    check("single_busy_end", 32'(busy_o), 32'd0);

    // Simultaneous after reset: 1 then 2, strictly sequential
    do_reset();
    rb = rsp_idx_log.size();
    eb = ev_log.size();
    operand[31:16] = 16'd81;
    operand[47:32] = 16'd225;
    req = 4'b0110;
    run(300, rb + 2, 1'b0, ok);
    check("simul_done", 32'(ok), 32'd1);
    if (ok) begin
      check("simul_ev0", ev_log[eb], 101);
      check("simul_ev1", ev_log[eb + 1], 201);
      check("simul_ev2", ev_log[eb + 2], 102);
      check("simul_ev3", ev_log[eb + 3], 202);
      check("simul_data1", rsp_data_log[rb], 9);
      check("simul_data2", rsp_data_log[rb + 1], 15);
    end

    // Fairness: all four continuously requesting
    do_reset();
    rb = rsp_idx_log.size();
    gb = gnt_log.size();
    operand = {16'd16, 16'd9, 16'd4, 16'd1};
    req = 4'b1111;
    run(1500, rb + 8, 1'b1, ok);
    check("fair_done", 32'(ok), 32'd1);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        check("fair_grant", gnt_log[gb + k], k % 4);
        check("fair_rsp_idx", rsp_idx_log[rb + k], k % 4);
        check("fair_rsp_data", rsp_data_log[rb + k], (k % 4) + 1);
      end
    end

    // Reset during WAIT_DONE after granting requester 2
    do_reset();
    operand = 64'd0;
    operand[47:32] = 16'd100;
    req = 4'b0100;
    @(negedge clk);
    check("midrst_ack", 32'(ack_o), 32'd4);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 32'(busy_o), 32'd1);
    rb = rsp_idx_log.size();
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    run(60, 1000, 1'b0, ok);
    check("midrst_no_rsp", rsp_idx_log.size() - rb, 0);

    // rr back at 0 (otherwise 3 would win) plus edge operands 0 and 65535
    rb = rsp_idx_log.size();
    gb = gnt_log.size();
    operand[31:16] = 16'd0;
    operand[63:48] = 16'd65535;
    req = 4'b1010;
    run(300, rb + 2, 1'b0, ok);
    check("edge_done", 32'(ok), 32'd1);
    if (ok) begin
      check("edge_first_grant", gnt_log[gb], 1);
      check("edge_rsp_idx0", rsp_idx_log[rb], 1);
      check("edge_rsp_zero", rsp_data_log[rb], 0);
      check("edge_rsp_idx1", rsp_idx_log[rb + 1], 3);
      check("edge_rsp_max", rsp_data_log[rb + 1], 255);
    end
    run(40, 1000, 1'b0, ok);

    // Plain request on requester 3 after the reset: 49 -> 7
    rb = rsp_idx_log.size();
    operand[63:48] = 16'd49;
    req = 4'b1000;
    @(negedge clk);
    check("req3_ack", 32'(ack_o), 32'd8);
    req = req & ~ack_o;
    run(200, rb + 1, 1'b0, ok);
    check("req3_done", 32'(ok), 32'd1);
    if (ok) begin
      check("req3_rsp_idx", rsp_idx_log[rb], 3);
      check("req3_rsp_data", rsp_data_log[rb], 7);
    end

`ifdef SQRT_TIMEOUT_EN
    // Hung core: abort exactly TIMEOUT cycles after entering WAIT_DONE
    do_reset();
    hang = 1'b1;
    operand[47:32] = 16'd16;
    req = 4'b0100;
    @(negedge clk);
    check("to_ack", 32'(ack_o), 32'd4);
    req  = 4'b0000;
    n    = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (rsp_valid_o != 4'b0) seen = 1'b1;
    end
    check("to_latency", n, 21);
    check("to_rsp_valid", 32'(rsp_valid_o), 32'd4);
    check("to_rsp_err", 32'(rsp_err_o), 32'd1);
    check("to_rsp_data", 32'(rsp_data_o), 32'd0);
    check("to_core_rst", 32'(core_rst_o), 32'd1);
    @(negedge clk);
    check("to_busy_after", 32'(busy_o), 32'd0);
    check("to_core_rst_pulse", 32'(core_rst_o), 32'd0);
    check("to_rsp_valid_pulse", 32'(rsp_valid_o), 32'd0);
    hang = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
